// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: op encodings, FSM states, illegal-op data pattern and default widths for reg_bus_master
package reg_bus_pkg;
   localparam int DEF_REG_WIDTH     = 32;
   localparam int DEF_ADDR_WIDTH    = 6;
   localparam int DEF_TIMEOUT_WIDTH = 16;
   localparam logic [31:0] BAD_DATA = 32'habadbeef;
   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_POLL = 2'b10,
      OP_ILL  = 2'b11
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_POLL_WAIT,
      S_RESP
   } state_e;
endpackage

// File: rtl/reg_bus_master.sv
// reg_bus_master: command-driven register bus master (write/read/poll); poll op enabled by REG_BUS_MASTER_POLL_EN
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int REG_WIDTH     = DEF_REG_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr,
   input  logic [REG_WIDTH-1:0]     cmd_data,
   input  logic [REG_WIDTH-1:0]     cmd_mask,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [REG_WIDTH-1:0]     rsp_data,
   output logic                     rsp_err,
   output logic                     bus_sel,
   output logic                     bus_wr_rd,
   output logic [ADDR_WIDTH-1:0]    bus_addr,
   output logic [REG_WIDTH-1:0]     bus_wdata,
   input  logic [REG_WIDTH-1:0]     bus_rdata,
   output logic                     busy
);
   state_e                r_state, w_next;
   op_e                   r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [REG_WIDTH-1:0]  r_data, r_rsp_data;
   logic                  r_rsp_err;
   logic                  w_accept, w_illegal, w_done, w_poll_err;

   assign w_accept = r_state == S_IDLE && cmd_valid;

`ifdef REG_BUS_MASTER_POLL_EN
   logic [REG_WIDTH-1:0]     r_mask;
   logic [TIMEOUT_WIDTH-1:0] r_limit, r_cnt, w_cnt_inc, w_limit;
   logic                     w_match;

   assign w_illegal  = cmd_op == OP_ILL;
   assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + TIMEOUT_WIDTH'(1);
   assign w_limit    = r_limit == '0 ? TIMEOUT_WIDTH'(1) : r_limit;
   assign w_match    = ((bus_rdata ^ r_data) & r_mask) == '0;
   assign w_done     = r_op != OP_POLL || w_match || w_cnt_inc == w_limit;
   assign w_poll_err = r_op == OP_POLL && !w_match;

   // poll context: mask/limit latched on accept, attempt counter bumped on every bus read
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_mask  <= '0;
         r_limit <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_mask  <= cmd_mask;
         r_limit <= timeout_limit;
         r_cnt   <= '0;
      end else if (r_state == S_ACCESS)
         r_cnt <= w_cnt_inc;
`else
   logic w_unused_cfg;

   assign w_illegal    = cmd_op[1];
   assign w_done       = 1'b1;
   assign w_poll_err   = 1'b0;
   assign w_unused_cfg = ^{cmd_mask, timeout_limit};
`endif

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   // command latch and response capture; illegal ops get their response at accept time
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_op       <= OP_WR;
         r_addr     <= '0;
         r_data     <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept) begin
         r_op       <= op_e'(cmd_op);
         r_addr     <= cmd_addr;
         r_data     <= cmd_data;
         r_rsp_data <= w_illegal ? REG_WIDTH'(BAD_DATA) : '0;
         r_rsp_err  <= w_illegal;
      end else if (r_state == S_ACCESS) begin
         r_rsp_data <= r_op == OP_WR ? '0 : bus_rdata;
         r_rsp_err  <= w_poll_err;
      end

   // next-state and handshake outputs
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      bus_sel   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = w_illegal ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            bus_sel = 1'b1;
            w_next  = w_done ? S_RESP : S_POLL_WAIT;
         end
         S_POLL_WAIT: w_next = S_ACCESS;
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus_wr_rd = bus_sel && r_op == OP_WR;
   assign bus_addr  = bus_sel ? r_addr : '0;
   assign bus_wdata = bus_wr_rd ? r_data : '0;
   assign busy      = r_state != S_IDLE;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed self-checking bench for reg_bus_master (poll tests follow REG_BUS_MASTER_POLL_EN)
module tb_reg_bus_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [5:0]  cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic [31:0] cmd_mask = '0;
   logic [15:0] timeout_limit = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        bus_sel, bus_wr_rd;
   logic [5:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic        busy;

   int          checks = 0, errors = 0;
   int          n_sel = 0, base = 0, bad_bus = 0;
   logic        l_wr;
   logic [5:0]  l_addr;
   logic [31:0] l_wdata;
   logic [31:0] rd_q [8];

   assign bus_rdata = rd_q[3'(n_sel - base)];

   reg_bus_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .timeout_limit(timeout_limit),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .bus_sel(bus_sel), .bus_wr_rd(bus_wr_rd), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus_sel === 1'b1) begin
         n_sel   <= n_sel + 1;
         l_wr    <= bus_wr_rd;
         l_addr  <= bus_addr;
         l_wdata <= bus_wdata;
      end

   always @(negedge clk)
      if ((bus_sel !== 1'b1 && (bus_wr_rd !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0)) ||
          (bus_sel === 1'b1 && bus_wr_rd === 1'b0 && bus_wdata !== '0))
         bad_bus <= bad_bus + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                       input logic [31:0] mask, input logic [15:0] lim);
      @(negedge clk);
      cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; timeout_limit = lim;
      cmd_valid = 1'b1;
      base = n_sel;
      check("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                      input logic [31:0] mask, input logic [15:0] lim, input int hold,
                      output logic [31:0] d, output logic e, output int ls, output int lr, output int nacc);
      int b0, unstable;
      send(op, addr, data, mask, lim);
      b0 = base;
      ls = -1;
      lr = -1;
      for (int t = 1; t <= 200; t++) begin
         if (bus_sel === 1'b1 && ls < 0) ls = t;
         if (rsp_valid === 1'b1) begin
            lr = t;
            break;
         end
         @(negedge clk);
      end
      if (lr < 0) check("rsp_wait_expired", 0, 1);
      d = rsp_data;
      e = rsp_err;
      unstable = 0;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_op = 2'b00;
         cmd_addr = 6'(h);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e || cmd_ready !== 1'b0 || bus_sel !== 1'b0)
            unstable++;
      end
      cmd_valid = 1'b0;
      if (hold > 0) check("hold_stable", unstable, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_after_ready", rsp_valid, 0);
      nacc = n_sel - b0;
   endtask

   task automatic pulse_reset();
      int seen;
      rst = 1'b1;
      #1;
      check("rst_bus_sel", bus_sel, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_data", rsp_data, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || bus_sel !== 1'b0) seen++;
      end
      check("post_rst_quiet", seen, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          ls, lr, nacc;
      for (int i = 0; i < 8; i++) rd_q[i] = '0;
      #1;
      check("reset_bus_sel", bus_sel, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_bus_addr", bus_addr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_cmd_ready", cmd_ready, 1);

      run(2'b00, 6'h4, 32'h5, 32'h0, 16'd0, 0, d, e, ls, lr, nacc);
      check("wr_sel_lat", ls, 1);
      check("wr_rsp_lat", lr, 2);
      check("wr_accesses", nacc, 1);
      check("wr_wr_rd", l_wr, 1);
      check("wr_addr", l_addr, 6'h4);
      check("wr_wdata", l_wdata, 32'h5);
      check("wr_rsp_data", d, 0);
      check("wr_rsp_err", e, 0);

      rd_q[0] = 32'h5;
      run(2'b01, 6'h4, 32'h77, 32'h0, 16'd0, 0, d, e, ls, lr, nacc);
      check("rd_sel_lat", ls, 1);
      check("rd_rsp_lat", lr, 2);
      check("rd_accesses", nacc, 1);
      check("rd_wr_rd", l_wr, 0);
      check("rd_addr", l_addr, 6'h4);
      check("rd_wdata", l_wdata, 0);
      check("rd_rsp_data", d, 32'h5);
      check("rd_rsp_err", e, 0);

      rd_q[0] = 32'hdeadbeef;
      run(2'b01, 6'h3c, 32'h0, 32'h0, 16'd0, 0, d, e, ls, lr, nacc);
      check("rd2_addr", l_addr, 6'h3c);
      check("rd2_rsp_data", d, 32'hdeadbeef);
      check("rd2_accesses", nacc, 1);

      run(2'b11, 6'h8, 32'h1, 32'h0, 16'd0, 10, d, e, ls, lr, nacc);
      check("ill_no_sel", ls, -1);
      check("ill_rsp_lat", lr, 1);
      check("ill_accesses", nacc, 0);
      check("ill_rsp_data", d, 32'habadbeef);
      check("ill_rsp_err", e, 1);

`ifdef REG_BUS_MASTER_POLL_EN
      rd_q[0] = 32'h1; rd_q[1] = 32'h1; rd_q[2] = 32'h0;
      run(2'b10, 6'h8, 32'h0, 32'h1, 16'd5, 0, d, e, ls, lr, nacc);
      check("poll_accesses", nacc, 3);
      check("poll_rsp_lat", lr, 6);
      check("poll_addr", l_addr, 6'h8);
      check("poll_wr_rd", l_wr, 0);
      check("poll_rsp_data", d, 0);
      check("poll_rsp_err", e, 0);

      for (int i = 0; i < 8; i++) rd_q[i] = 32'h1;
      run(2'b10, 6'h8, 32'h0, 32'h1, 16'd3, 0, d, e, ls, lr, nacc);
      check("poll_to3_accesses", nacc, 3);
      check("poll_to3_rsp_lat", lr, 6);
      check("poll_to3_rsp_err", e, 1);
      check("poll_to3_rsp_data", d, 32'h1);

      run(2'b10, 6'h8, 32'h0, 32'h1, 16'd0, 0, d, e, ls, lr, nacc);
      check("poll_to0_accesses", nacc, 1);
      check("poll_to0_rsp_lat", lr, 2);
      check("poll_to0_rsp_err", e, 1);

      rd_q[0] = 32'h12345678;
      run(2'b10, 6'h20, 32'h9abc5678, 32'h0000ffff, 16'd4, 0, d, e, ls, lr, nacc);
      check("poll_mask_accesses", nacc, 1);
      check("poll_mask_rsp_data", d, 32'h12345678);
      check("poll_mask_rsp_err", e, 0);

      for (int i = 0; i < 8; i++) rd_q[i] = 32'h1;
      send(2'b10, 6'h8, 32'h0, 32'h1, 16'd5);
      check("midpoll_sel", bus_sel, 1);
      @(negedge clk);
      check("midpoll_wait_sel", bus_sel, 0);
      pulse_reset();
      check("midpoll_accesses", n_sel - base, 1);
`else
      run(2'b10, 6'h8, 32'h0, 32'h1, 16'd5, 0, d, e, ls, lr, nacc);
      check("poll_off_accesses", nacc, 0);
      check("poll_off_rsp_lat", lr, 1);
      check("poll_off_rsp_data", d, 32'habadbeef);
      check("poll_off_rsp_err", e, 1);

      send(2'b11, 6'h0, 32'h0, 32'h0, 16'd0);
      check("midrsp_valid", rsp_valid, 1);
      pulse_reset();
      check("midrsp_accesses", n_sel - base, 0);
`endif

      rd_q[0] = 32'h00005a5a;
      for (int i = 1; i < 8; i++) rd_q[i] = '0;
      run(2'b01, 6'h10, 32'h0, 32'h0, 16'd0, 0, d, e, ls, lr, nacc);
      check("after_rst_rd_lat", lr, 2);
      check("after_rst_rd_accesses", nacc, 1);
      check("after_rst_rd_data", d, 32'h00005a5a);
      check("after_rst_rd_err", e, 0);

      check("bus_idle_zero", bad_bus, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width of bus and command/response data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, register byte-address width.
REQ-003 SHALL have parameter TIMEOUT_WIDTH, default 16, width of poll attempt limit and counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 cmd_op  input  2  00 write, 01 read, 10 poll, 11 illegal.
REQ-010 cmd_addr  input  ADDR_WIDTH  target register byte address.
REQ-011 cmd_data  input  REG_WIDTH  write data, or poll expected value.
REQ-012 cmd_mask  input  REG_WIDTH  poll compare mask.
REQ-013 timeout_limit  input  TIMEOUT_WIDTH  maximum poll reads; 0 treated as 1.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-016 rsp_data  output  REG_WIDTH  read/poll captured data; 0 for write.
REQ-017 rsp_err  output  1  poll timeout or illegal/disabled op.
REQ-018 bus_sel  output  1  register bus select, one cycle per access.
REQ-019 bus_wr_rd  output  1  1 write, 0 read.
REQ-020 bus_addr, bus_wdata  output  ADDR_WIDTH, REG_WIDTH  access address and write data.
REQ-021 bus_rdata  input  REG_WIDTH  combinational read data from responder, valid during bus_sel with bus_wr_rd=0.
REQ-022 busy  output  1  high in any state except IDLE.

Function
REQ-023 SHALL implement FSM IDLE, ACCESS, POLL_WAIT, RESP.
REQ-024 IDLE: cmd_ready=1; on cmd_valid latch op/addr/data/mask/limit, clear attempt counter, go ACCESS (op 11 goes directly to RESP).
REQ-025 ACCESS: bus_sel=1 exactly one cycle driving latched addr/data; bus_wr_rd=1 for write, 0 for read/poll; bus_wdata=0 on reads.
REQ-026 Read: register bus_rdata at end of ACCESS cycle into rsp_data, go RESP; latency cmd accept cycle N, bus_sel N+1, rsp_valid N+2.
REQ-027 Write: go RESP with rsp_data=0, rsp_err=0.
REQ-028 Poll: capture bus_rdata, increment attempt counter (saturating); match = ((rdata ^ cmd_data) & cmd_mask)==0.
REQ-029 Poll match -> RESP err=0; no match and attempts == max(timeout_limit,1) -> RESP err=1 with last read data; else POLL_WAIT.
REQ-030 POLL_WAIT: bus_sel=0 for one cycle, then ACCESS.
REQ-031 Illegal op: no bus access, RESP with rsp_data=32'habadbeef (truncated/zero-extended to REG_WIDTH), rsp_err=1.
REQ-032 RESP: rsp_valid=1, rsp_data/rsp_err stable while rsp_ready low; cmd_ready=0; on rsp_ready go IDLE, next command accepted no earlier than following cycle.
REQ-033 bus_sel SHALL never assert outside ACCESS; bus outputs 0 when bus_sel=0.
REQ-034 cmd inputs SHALL be ignored outside IDLE.

Reset
REQ-035 rst assertion SHALL immediately force IDLE, bus_sel=0, bus_wr_rd=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, counter=0; cmd_ready=1 after release.
REQ-036 Reset mid-poll or mid-RESP SHALL discard the command with no response.

Configuration
REQ-037 Macro REG_BUS_MASTER_POLL_EN defined: poll op per REQ-028..030.
REQ-038 Macro undefined: op 10 handled as illegal (REQ-031), no poll counter/compare logic, timeout_limit ignored.

Structure
REQ-039 Package reg_bus_pkg SHALL hold op encodings, FSM state enum, BAD_DATA constant, default width constants.
REQ-040 Single module; no sub-module.

Verification
REQ-041 Write op addr 'h4 data 'h5 -> one bus_sel cycle wr_rd=1 addr 'h4 wdata 'h5; rsp_valid two cycles after accept, data 0, err 0.
REQ-042 Read addr 'h4 with responder returning 'h5 -> bus_sel wr_rd=0, rsp_data 'h5, err 0.
REQ-043 Poll addr 'h8 expect 0 mask 1, rdata bit0 =1,1,0, limit 5 -> three reads with one-cycle gaps, rsp err 0, data 0.
REQ-044 Poll never matching, limit 3 -> exactly three bus reads, rsp_err 1; limit 0 -> exactly one read, err 1.
REQ-045 Op 11 -> no bus_sel, rsp 'habadbeef err 1; rsp_ready held low 10 cycles -> rsp stable, cmd_ready 0.
REQ-046 rst pulsed during POLL_WAIT -> bus_sel/rsp_valid 0 same cycle, no response, next read completes normally.
